// File: rtl/uart_rx_receiver.sv
// uart_rx_receiver
//   Bit-per-clock UART receive stage sitting directly behind the UART
//   transmitter in the same clock domain. It deserialises start/data/parity/
//   stop frames, including multi-word packets whose follow-on words carry no
//   start bit. It also drives the rx_ready handshake back to the transmitter
//   and holds each received word in a one-entry register with valid/accept
//   flow control.
//
// Optional feature macro: UART_RX_ERR_CNT_EN
//   When defined, saturating parity/frame error counters are added as ports.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   serial_in      serial line from transmitter, idles high
//   packet_struct  [3:0] data bits per word minus 1, [7:5] words per packet minus 1
//   rx_ready       receiver can take the next word (start or follow-on)
//   rx_data        held word, LSB = first bit received, unused high bits 0
//   rx_valid       holding register full
//   rx_accept      consumer takes rx_data when rx_valid & rx_accept
//   rx_last        held word is the last word of its packet
//   parity_err     even-parity mismatch for held word
//   frame_err      stop bit sampled low for held word
//   parity_err_cnt saturating count of parity errors (macro only)
//   frame_err_cnt  saturating count of frame errors (macro only)
module uart_rx_receiver #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              serial_in,
  input  logic [7:0]        packet_struct,
  output logic              rx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_accept,
  output logic              rx_last,
  output logic              parity_err,
  output logic              frame_err
`ifdef UART_RX_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0]  parity_err_cnt,
  output logic [CNT_W-1:0]  frame_err_cnt
`endif
);

  localparam int BIT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_PARITY, S_STOP, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [BIT_W-1:0]  n_q, n_d;
  logic [2:0]        word_cnt_q, word_cnt_d;
  logic [2:0]        m_q, m_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_bad_q, par_bad_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_last_q, rx_last_d;
  logic              parity_err_q, parity_err_d;
  logic              frame_err_q, frame_err_d;
  logic [CNT_W-1:0]  par_cnt_q, par_cnt_d;
  logic [CNT_W-1:0]  frm_cnt_q, frm_cnt_d;

  // Bit 4 of packet_struct carries no meaning.
  logic pkt_unused;
  assign pkt_unused = packet_struct[4];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Ready only with an empty holding register and at a word boundary, so the
  // transmitter can never advance while a received word is still pending.
  assign rx_ready = ~rx_valid_q & ((state_q == S_IDLE) | (state_q == S_WAIT));

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    n_d          = n_q;
    word_cnt_d   = word_cnt_q;
    m_d          = m_q;
    shift_d      = shift_q;
    par_bad_d    = par_bad_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    rx_last_d    = rx_last_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    par_cnt_d    = par_cnt_q;
    frm_cnt_d    = frm_cnt_q;

    // A load only happens in STOP, where rx_valid is already 0, so the
    // consumer-side clear can be applied first and overridden below.
    if (rx_valid_q && rx_accept) rx_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!serial_in && rx_ready) begin
          state_d    = S_DATA;
          n_d        = packet_struct[BIT_W-1:0];
          m_d        = packet_struct[7:5];
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          shift_d    = '0;
        end
      end
      S_DATA: begin
        shift_d[bit_cnt_q] = serial_in;
        bit_cnt_d          = bit_cnt_q + BIT_W'(1);
        if (bit_cnt_q == n_q) state_d = S_PARITY;
      end
      S_PARITY: begin
        // Bits above N are 0 in shift, so the full-width XOR is even parity
        // over just the transmitted bits.
        par_bad_d = serial_in ^ (^shift_q);
        state_d   = S_STOP;
      end
      S_STOP: begin
        rx_data_d    = shift_q;
        parity_err_d = par_bad_q;
        frame_err_d  = ~serial_in;
        rx_last_d    = (word_cnt_q == m_q);
        rx_valid_d   = 1'b1;
        if (par_bad_q)  par_cnt_d = sat_inc(par_cnt_q);
        if (!serial_in) frm_cnt_d = sat_inc(frm_cnt_q);
        state_d = (word_cnt_q == m_q) ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (rx_ready) begin
          state_d    = S_DATA;
          word_cnt_d = word_cnt_q + 3'd1;
          bit_cnt_d  = '0;
          shift_d    = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      n_q          <= '0;
      word_cnt_q   <= '0;
      m_q          <= '0;
      shift_q      <= '0;
      par_bad_q    <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_last_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      par_cnt_q    <= '0;
      frm_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      n_q          <= n_d;
      word_cnt_q   <= word_cnt_d;
      m_q          <= m_d;
      shift_q      <= shift_d;
      par_bad_q    <= par_bad_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_last_q    <= rx_last_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      par_cnt_q    <= par_cnt_d;
      frm_cnt_q    <= frm_cnt_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_last    = rx_last_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;

`ifdef UART_RX_ERR_CNT_EN
  assign parity_err_cnt = par_cnt_q;
  assign frame_err_cnt  = frm_cnt_q;
`else
  // Counters have no observer without the macro.
  logic cnt_unused;
  assign cnt_unused = ^{par_cnt_q, frm_cnt_q};
`endif

endmodule

// File: tb/tb_uart_rx_receiver.sv
`timescale 1ns/1ps
module tb_uart_rx_receiver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        serial_in = 1'b1;
  logic [7:0]  packet_struct = 8'h00;
  logic        rx_ready;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_accept = 1'b1;
  logic        rx_last;
  logic        parity_err;
  logic        frame_err;
`ifdef UART_RX_ERR_CNT_EN
  logic [7:0]  parity_err_cnt;
  logic [7:0]  frame_err_cnt;
`endif

  uart_rx_receiver #(.DATA_W(16), .CNT_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .serial_in     (serial_in),
    .packet_struct (packet_struct),
    .rx_ready      (rx_ready),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_accept     (rx_accept),
    .rx_last       (rx_last),
    .parity_err    (parity_err),
    .frame_err     (frame_err)
`ifdef UART_RX_ERR_CNT_EN
    ,
    .parity_err_cnt(parity_err_cnt),
    .frame_err_cnt (frame_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic        perr;
    logic        ferr;
  } word_t;

  word_t exp_q[$];
  word_t obs_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Consumer control.
  int   accept_mode = 0;
  int   stall_arm = 0;
  int   stall_left = 0;
  int   stall_viol = 0;
  int   rise_cyc = -1;
  logic valid_prev = 1'b0;

  // Transmitter-side bookkeeping.
  int          last_bit_cyc = 0;
  int          hs_w [8];
  logic [15:0] pw [8];

  // Consumer: decides rx_accept each cycle and collects accepted words.
  always @(negedge clk) begin
    if (!rst_n) begin
      rx_accept  = 1'b1;
      stall_left = 0;
    end else begin
      if (rx_valid && !valid_prev) rise_cyc = cyc;
      if (rx_valid && stall_arm > 0) begin
        stall_left = stall_arm;
        stall_arm  = 0;
      end
      if (stall_left > 0) begin
        rx_accept = 1'b0;
        stall_left--;
        if (rx_ready !== 1'b0 || serial_in !== 1'b1) stall_viol++;
      end else begin
        rx_accept = (accept_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      if (rx_valid && rx_accept) obs_q.push_back({rx_data, rx_last, parity_err, frame_err});
    end
    valid_prev = rx_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Place a level on the line and hold it until the receiver is ready; the
  // next edge is the one on which the receiver moves into DATA.
  task automatic handshake(input logic lvl, output int waited);
    int t = 0;
    @(negedge clk);
    serial_in = lvl;
    while (rx_ready !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    waited = t;
    if (t >= 400) begin
      n_cmp++;
      n_bad++;
      $error("FAIL handshake: observed timeout expected rx_ready");
    end
  endtask

  task automatic send_bits(input logic [15:0] d, input int n, input logic par, input logic stp);
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      serial_in = d[i];
      if (i == n) last_bit_cyc = cyc;
    end
    @(negedge clk);
    serial_in = par;
    @(negedge clk);
    serial_in = stp;
  endtask

  // Reference transmitter + model: words come from pw[], the expected held
  // word is the low N+1 bits, the parity bit is even parity unless bad_par
  // marks it flipped, and the stop bit is 1 unless bad_stop marks it 0.
  task automatic send_packet(input logic [7:0] ps, input logic [7:0] bad_par, input logic [7:0] bad_stop);
    int          n;
    int          m;
    int          wt;
    logic [15:0] mask;
    n    = int'(ps[3:0]);
    m    = int'(ps[7:5]);
    mask = 16'hFFFF >> (15 - n);
    packet_struct = ps;
    for (int w = 0; w <= m; w++) begin
      logic [15:0] d;
      logic        par;
      d   = pw[w] & mask;
      par = (^d) ^ bad_par[w];
      handshake((w == 0) ? 1'b0 : 1'b1, wt);
      hs_w[w] = wt;
      send_bits(d, n, par, ~bad_stop[w]);
      exp_q.push_back({d, (w == m), bad_par[w], bad_stop[w]});
    end
    @(negedge clk);
    serial_in = 1'b1;
  endtask

  task automatic check_words(input string tag);
    int t = 0;
    while (obs_q.size() < exp_q.size() && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      word_t e;
      word_t o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk({tag, "_data"}, {16'h0, o.data}, {16'h0, e.data});
      chk({tag, "_last"}, {31'h0, o.last}, {31'h0, e.last});
      chk({tag, "_perr"}, {31'h0, o.perr}, {31'h0, e.perr});
      chk({tag, "_ferr"}, {31'h0, o.ferr}, {31'h0, e.ferr});
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'h0, rx_valid}, 32'h0);
    chk("rst_ready", {31'h0, rx_ready}, 32'h1);
    chk("rst_data",  {16'h0, rx_data}, 32'h0);
    chk("rst_last",  {31'h0, rx_last}, 32'h0);
    chk("rst_perr",  {31'h0, parity_err}, 32'h0);
    chk("rst_ferr",  {31'h0, frame_err}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single 8-bit word, latency.
    pw[0] = 16'h00A5;
    send_packet(8'h07, 8'h00, 8'h00);
    check_words("t1");
    chk("t1_latency", rise_cyc - last_bit_cyc, 32'd3);

    // 2: three 4-bit words, immediate accept.
    pw[0] = 16'h0005; pw[1] = 16'h000A; pw[2] = 16'h000F;
    send_packet(8'h43, 8'h00, 8'h00);
    check_words("t2");

    // 3: same packet, consumer stalls 10 cycles on word 0.
    stall_arm  = 10;
    stall_viol = 0;
    send_packet(8'h43, 8'h00, 8'h00);
    check_words("t3");
    chk("t3_stall_viol", stall_viol, 32'd0);
    chk("t3_hs_wait_ge10", {31'h0, (hs_w[1] >= 10)}, 32'h1);

    // 4: bad parity.
    pw[0] = 16'h0001;
    send_packet(8'h07, 8'h01, 8'h00);
    check_words("t4");

    // 5: stop bit low on a 16-bit word, then a clean packet.
    pw[0] = 16'hFFFF;
    send_packet(8'h0F, 8'h00, 8'h01);
    check_words("t5a");
    pw[0] = 16'h005A;
    send_packet(8'h07, 8'h00, 8'h00);
    check_words("t5b");

    // 6: asynchronous reset in the middle of DATA.
    packet_struct = 8'h07;
    begin
      int wt;
      handshake(1'b0, wt);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      serial_in = i[0];
    end
    @(posedge clk);
    #2;
    chk("t6_ready_in_data", {31'h0, rx_ready}, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {31'h0, rx_valid}, 32'h0);
    chk("t6_rst_ready", {31'h0, rx_ready}, 32'h1);
    chk("t6_rst_data",  {16'h0, rx_data}, 32'h0);
    @(negedge clk);
    serial_in = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pw[0] = 16'h003C;
    send_packet(8'h07, 8'h00, 8'h00);
    check_words("t6");

    // Randomized packets with random accept and random corruption.
    accept_mode = 1;
    for (int p = 0; p < 25; p++) begin
      logic [7:0] ps;
      logic [7:0] bp;
      logic [7:0] bs;
      ps = {3'($urandom_range(0, 3)), 1'($urandom), 4'($urandom_range(0, 15))};
      bp = '0;
      bs = '0;
      for (int w = 0; w < 8; w++) begin
        pw[w] = 16'($urandom);
        bp[w] = ($urandom_range(0, 3) == 0);
        bs[w] = ($urandom_range(0, 3) == 0);
      end
      send_packet(ps, bp, bs);
      check_words("rnd");
    end
    accept_mode = 0;

`ifdef UART_RX_ERR_CNT_EN
    // Error counters: 300 parity errors saturate, 5 frame errors count.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("cnt_rst_par", {24'h0, parity_err_cnt}, 32'h0);
    chk("cnt_rst_frm", {24'h0, frame_err_cnt}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int p = 0; p < 300; p++) begin
      pw[0] = 16'($urandom);
      send_packet(8'h00, 8'h01, (p < 5) ? 8'h01 : 8'h00);
    end
    check_words("cnt");
    chk("cnt_par_sat", {24'h0, parity_err_cnt}, 32'hFF);
    chk("cnt_frm", {24'h0, frame_err_cnt}, 32'd5);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
